// File: rtl/alu32_trunc_issue_if.sv
// alu32_trunc_issue_if: operand-in and result-out handshake bundle for the truncation issue stage
interface alu32_trunc_issue_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_in1;
    logic        s_mode;
    logic [4:0]  s_amt;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_bypass;
    modport slave (
        input  s_valid, s_in1, s_mode, s_amt, m_ready,
        output s_ready, m_valid, m_data, m_bypass
    );
    modport master (
        output s_valid, s_in1, s_mode, s_amt, m_ready,
        input  s_ready, m_valid, m_data, m_bypass
    );
endinterface

// File: rtl/alu32_trunc_issue.sv
// alu32_trunc_issue: 2-entry operand FIFO, registered issue to the truncation unit, held result port
module alu32_trunc_issue #(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu32_trunc_issue_if.slave  bus,
    output logic [31:0]         trunc_in1,
    output logic [31:0]         trunc_in2,
    input  logic [31:0]         trunc_cout1,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
    state_t      state, state_n;
    logic [37:0] mem [DEPTH];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic [37:0] head;
    logic        head_byp, push, pop, hs;
    // entry layout: {in1, mode, amt}; mode=1/amt=0 would ask the unit for a 32-bit shift
    assign head     = mem[rd_ptr];
    assign head_byp = head[5] && head[4:0] == 5'd0;
    assign bus.s_ready = count < 2'(DEPTH);
    assign push     = bus.s_valid && bus.s_ready;
    assign hs       = state == HOLD && bus.m_valid && bus.m_ready;
    assign pop      = count != 2'd0 && (state == IDLE || hs);
    assign busy     = state != IDLE || count != 2'd0;
    always_comb begin
        state_n = state;
        state_n = pop ? (head_byp ? HOLD : DRIVE) :
                  state == DRIVE ? HOLD :
                  hs ? IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {bus.s_in1, bus.s_mode, bus.s_amt};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count        <= 2'd0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            bus.m_valid  <= 1'b0;
            bus.m_data   <= 32'd0;
            bus.m_bypass <= 1'b0;
            trunc_in1    <= 32'd0;
            trunc_in2    <= 32'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (pop && head_byp) begin
                bus.m_valid  <= 1'b1;
                bus.m_data   <= head[37:6];
                bus.m_bypass <= 1'b1;
            end else if (pop) begin
                bus.m_valid <= 1'b0;
                trunc_in1   <= head[37:6];
                trunc_in2   <= {head[5], 26'd0, head[4:0]};
            end else if (state == DRIVE) begin
                bus.m_valid  <= 1'b1;
                bus.m_data   <= trunc_cout1;
                bus.m_bypass <= 1'b0;
            end else if (hs) begin
                bus.m_valid <= 1'b0;
            end
        end
endmodule

// File: doc/alu32_trunc_issue.md
# alu32_trunc_issue

Operand issue and result capture stage wrapped around the ALU32 truncation unit. It accepts operand/command beats over a valid/ready handshake and buffers them in a 2-entry FIFO. It drives registered In1/In2 into the combinational truncation unit, samples that unit's cout1 after one settle cycle, and holds the result on a valid/ready output port. It gives the truncation unit registered, glitch-free operands and decouples it from producer and consumer stalls.

## Interface
Parameters:
- DEPTH, 2, input FIFO entries; only 2 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input FIFO can accept a beat.
- s_in1  in  32  operand word.
- s_mode  in  1  mode bit; becomes In2[31] of the truncation unit.
- s_amt  in  5  amount; becomes In2[4:0].
- trunc_in1  out  32  registered operand to truncation unit In1.
- trunc_in2  out  32  registered {s_mode, 26'b0, s_amt} to truncation unit In2.
- trunc_cout1  in  32  truncation unit result (combinational from trunc_in1/in2).
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts result.
- m_data  out  32  result word.
- m_bypass  out  1  result came from the bypass path, not from the unit.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.

## Operation
- Input FIFO: 2 entries of {in1, mode, amt}; registered storage, no combinational pass-through.
  - s_ready = (count < 2). A write occurs when s_valid && s_ready.
  - Simultaneous push and pop when full is not allowed, because s_ready is already low. Simultaneous push and pop at count 1 leaves count at 1.
- Bypass rule: an entry with mode=1 and amt=0 is not issued. The unit would form 32-0=32, which is outside the 5-bit shift range. Instead, m_data = in1 and m_bypass = 1.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE:
    - FIFO empty: stay in IDLE.
    - FIFO non-empty and head is bypass: pop; m_data ← in1, m_bypass ← 1, m_valid ← 1; go to HOLD. trunc_in1/trunc_in2 are unchanged.
    - FIFO non-empty and head is not bypass: pop; trunc_in1 ← in1, trunc_in2 ← {mode, 26'b0, amt}; go to DRIVE.
  - DRIVE (exactly one cycle): m_data ← trunc_cout1, m_bypass ← 0, m_valid ← 1; go to HOLD.
  - HOLD: m_valid, m_data and m_bypass stay stable until m_valid && m_ready. On that handshake:
    - FIFO non-empty: perform the IDLE pop action in the same edge. m_valid drops unless the popped entry is a bypass entry; a bypass entry reloads m_valid=1 immediately.
    - FIFO empty: m_valid ← 0; go to IDLE.
- trunc_in1/trunc_in2 hold their last issued values between operations.
- Results are delivered strictly in acceptance order.

## Timing
- Reset (rst_n low, asynchronous):
  - FIFO count = 0, state = IDLE.
  - s_ready = 1.
  - m_valid = 0, m_data = 0, m_bypass = 0.
  - trunc_in1 = 0, trunc_in2 = 0.
  - busy = 0.
- Reset mid-operation discards all buffered and in-flight entries. No partial result is emitted after reset release.
- Latency (idle block, m_ready=1), for a beat accepted at edge k:
  - Normal: popped and driven to the unit at edge k+1; m_valid high after edge k+2.
  - Bypass: m_valid high after edge k+1.
- Throughput with m_ready held high:
  - Normal entries: one result per 2 cycles (HOLD→DRIVE→HOLD).
  - Bypass entries: one result per cycle.
- m_ready low: the FIFO fills after 2 further accepts, then s_ready deasserts.
- s_ready reasserts the cycle after the pop that frees an entry.
- Outputs never change while m_valid && !m_ready.

## Test plan
Bench stub for all scenarios: trunc_cout1 = ~trunc_in1.
- Reset behaviour: hold rst_n low, then release. Then assert rst_n low while in DRIVE with the FIFO full. Required: all outputs at reset values immediately, with no clock edge needed; s_ready=1 after release; no m_valid until a new beat is accepted.
- Single normal op: s_in1=0x0000_00FF, mode=1, amt=3, m_ready=1, accepted at edge k. Required:
  - trunc_in2=0x8000_0003 after k+1.
  - m_valid with m_data=0xFFFF_FF00, m_bypass=0 after k+2.
- Bypass op: s_in1=0x1234_5678, mode=1, amt=0. Required: m_data=0x1234_5678, m_bypass=1 after k+1; trunc_in1 unchanged.
- Backpressure: m_ready=0; push in1 values A=1, B=2, C=3, D=4 back-to-back. Required:
  - A is held in HOLD; B and C fill the FIFO; s_ready=0 while D is presented.
  - After m_ready=1, results are 0xFFFF_FFFE, 0xFFFF_FFFD, 0xFFFF_FFFC, 0xFFFF_FFFB in order.
  - m_data is stable throughout the stall.
- Mixed stream at full rate: normal, bypass, normal with m_ready=1. Required: order preserved; the bypass result appears on the handshake edge directly after the first result; busy=0 only after the last handshake.
